shift_quantize: RTL and testbench

SHIFT_QUANTIZE -- requirements
Module: shift_quantize

---
 rtl/shift_quantize.sv | 147 ++++++++++++++
 tb/tb_shift_quantize.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_quantize.sv
// shift_quantize: two-stage shift/round/saturate quantizer on an AXI-Stream
// style sample path. The shift is latched while the layer is in PREAM.
// S1 applies the shift. S2 saturates to OUT_BITWIDTH and drives the outputs.
module shift_quantize #(
    parameter int DATA_BITWIDTH = 16,
    parameter int OUT_BITWIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               state,
    input  logic [DATA_BITWIDTH-1:0] shift_amount,
    input  logic                     shift_left,
    input  logic [DATA_BITWIDTH-1:0] s_tdata,
    input  logic                     s_tvalid,
    input  logic                     s_tlast,
    output logic                     s_tready,
    output logic [OUT_BITWIDTH-1:0]  m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    input  logic                     m_tready,
    output logic [15:0]              sat_count
);

    localparam logic [1:0] ST_PREAM = 2'b00;
    localparam int SHW = $clog2(DATA_BITWIDTH);
    localparam int RW  = 2 * DATA_BITWIDTH;
    localparam logic [DATA_BITWIDTH-1:0] MAX_SH = DATA_BITWIDTH'(DATA_BITWIDTH - 1);
    localparam logic [15:0] SAT_MAX = 16'hFFFF;

    logic [DATA_BITWIDTH-1:0] sh_amt_q, sh_amt_d;
    logic                     sh_left_q, sh_left_d;
    logic [1:0]               prev_state_q, prev_state_d;
    logic                     s1_valid_q, s1_valid_d;
    logic [RW-1:0]            s1_r_q, s1_r_d;
    logic                     s1_last_q, s1_last_d;
    logic [OUT_BITWIDTH-1:0]  m_tdata_q, m_tdata_d;
    logic                     m_tvalid_q, m_tvalid_d;
    logic                     m_tlast_q, m_tlast_d;
    logic                     s2_sat_q, s2_sat_d;
    logic [15:0]              sat_count_q, sat_count_d;

    logic                     stall;
    logic                     in_xfer;
    logic                     out_xfer;
    logic                     pream_entry;
    logic [SHW-1:0]           n_eff;
    logic [DATA_BITWIDTH:0]   half;
    logic [DATA_BITWIDTH:0]   right_sum;
    logic [RW-1:0]            shifted;
    logic                     s1_sat;

    assign stall    = m_tvalid_q & ~m_tready;
    // No accepts during the reset cycle; held samples would be discarded anyway.
    assign s_tready = ~stall & (state != ST_PREAM) & ~rst;
    assign in_xfer  = s_tvalid & s_tready;
    assign out_xfer = m_tvalid_q & m_tready;
    assign pream_entry = (state == ST_PREAM) && (prev_state_q != ST_PREAM);

    assign m_tdata   = m_tdata_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
    assign sat_count = sat_count_q;

    // S1 shift datapath: clamp the shift, then left shift or round-half-up right shift.
    always_comb begin
        n_eff     = (sh_amt_q > MAX_SH) ? SHW'(DATA_BITWIDTH - 1) : sh_amt_q[SHW-1:0];
        half      = (DATA_BITWIDTH + 1)'(1) << (n_eff - SHW'(1));
        right_sum = {1'b0, s_tdata} + half;
        shifted   = '0;
        if (sh_left_q) begin
            shifted = RW'(s_tdata) << n_eff;
        end else if (n_eff == '0) begin
            shifted = RW'(s_tdata);
        end else begin
            shifted = RW'(right_sum >> n_eff);
        end
        s1_sat = |s1_r_q[RW-1:OUT_BITWIDTH];
    end

    // Next-state logic for the shift latch, both pipeline stages and the saturation counter.
    always_comb begin
        sh_amt_d     = sh_amt_q;
        sh_left_d    = sh_left_q;
        prev_state_d = state;
        s1_valid_d   = s1_valid_q;
        s1_r_d       = s1_r_q;
        s1_last_d    = s1_last_q;
        m_tdata_d    = m_tdata_q;
        m_tvalid_d   = m_tvalid_q;
        m_tlast_d    = m_tlast_q;
        s2_sat_d     = s2_sat_q;
        sat_count_d  = sat_count_q;

        if (state == ST_PREAM) begin
            sh_amt_d  = shift_amount;
            sh_left_d = shift_left;
        end

        // Both stages move together; an empty S1 pushes a bubble into S2.
        if (!stall) begin
            s1_valid_d = in_xfer;
            s1_r_d     = shifted;
            s1_last_d  = s_tlast;
            m_tvalid_d = s1_valid_q;
            m_tdata_d  = s1_sat ? {OUT_BITWIDTH{1'b1}} : s1_r_q[OUT_BITWIDTH-1:0];
            m_tlast_d  = s1_last_q;
            s2_sat_d   = s1_sat;
        end

        // Clearing on layer start takes priority over a saturating beat in that cycle.
        if (pream_entry) begin
            sat_count_d = '0;
        end else if (out_xfer && s2_sat_q && (sat_count_q != SAT_MAX)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_amt_q     <= '0;
            sh_left_q    <= 1'b0;
            prev_state_q <= '0;
            s1_valid_q   <= 1'b0;
            s1_r_q       <= '0;
            s1_last_q    <= 1'b0;
            m_tdata_q    <= '0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            s2_sat_q     <= 1'b0;
            sat_count_q  <= '0;
        end else begin
            sh_amt_q     <= sh_amt_d;
            sh_left_q    <= sh_left_d;
            prev_state_q <= prev_state_d;
            s1_valid_q   <= s1_valid_d;
            s1_r_q       <= s1_r_d;
            s1_last_q    <= s1_last_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            s2_sat_q     <= s2_sat_d;
            sat_count_q  <= sat_count_d;
        end
    end

endmodule

// File: tb/tb_shift_quantize.sv
// Bench for shift_quantize: driver pushes expected beats into a scoreboard
// computed by an arithmetic reference model; a negedge monitor pops and compares.
module tb_shift_quantize;

    localparam int DW = 16;
    localparam int OW = 8;
    localparam logic [1:0] PREAM = 2'b00;
    localparam logic [1:0] DATA  = 2'b01;
    localparam logic [1:0] QUIET = 2'b10;
    localparam logic [1:0] FINAL = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    state;
    logic [DW-1:0] shift_amount;
    logic          shift_left;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [OW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic [15:0]   sat_count;

    shift_quantize #(.DATA_BITWIDTH(DW), .OUT_BITWIDTH(OW)) dut (
        .clk(clk), .rst(rst), .state(state),
        .shift_amount(shift_amount), .shift_left(shift_left),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
        logic          sat;
        int            acc_cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int unsigned cur_amt  = 0;
    bit          cur_left = 1'b0;
    bit          lat_chk  = 1'b0;
    bit          rand_ready = 1'b0;
    logic [15:0] exp_cnt  = '0;
    logic [1:0]  prev_st  = PREAM;
    bit          prev_stall = 1'b0;
    logic [OW-1:0] prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: clamp shift, scale by a power of two with round-half-up, clip to OW bits.
    function automatic exp_t model(input int unsigned x, input int unsigned amt,
                                   input bit left, input bit last);
        exp_t            e;
        int unsigned     n;
        longint unsigned r;
        n = (amt > DW - 1) ? DW - 1 : amt;
        if (left)        r = longint'(x) * (longint'(1) << n);
        else if (n == 0) r = x;
        else             r = (longint'(x) + (longint'(1) << (n - 1))) / (longint'(1) << n);
        e.sat     = (r >= (longint'(1) << OW));
        e.data    = e.sat ? {OW{1'b1}} : r[OW-1:0];
        e.last    = last;
        e.acc_cyc = 0;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) m_tready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: scoreboard compare, stall-hold, handshake and sat_count model.
    initial forever begin
        exp_t e;
        bit   sat_x;
        @(negedge clk);
        if (rst) begin
            check("rst_s_tready", s_tready, 0);
            sb.delete();
            exp_cnt    = '0;
            prev_st    = PREAM;
            prev_stall = 1'b0;
        end else begin
            check("sat_count", sat_count, exp_cnt);
            if (prev_stall) begin
                check("hold_valid", m_tvalid, 1);
                check("hold_data", m_tdata, prev_data);
                check("hold_last", m_tlast, prev_last);
            end
            check("s_tready", s_tready, !(m_tvalid && !m_tready) && (state != PREAM));
            sat_x = 1'b0;
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", m_tdata, 32'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check("m_tdata", m_tdata, e.data);
                    check("m_tlast", m_tlast, e.last);
                    if (lat_chk) check("latency", cyc - e.acc_cyc, 2);
                    sat_x = e.sat;
                end
            end
            if (s_tvalid && s_tready) begin
                e = model(s_tdata, cur_amt, cur_left, s_tlast);
                e.acc_cyc = cyc;
                sb.push_back(e);
            end
            if (state == PREAM && prev_st != PREAM) exp_cnt = '0;
            else if (sat_x && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            prev_st    = state;
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pream(input int unsigned amt, input bit left, input int cycles);
        s_tvalid     = 1'b0;
        state        = PREAM;
        shift_amount = DW'(amt);
        shift_left   = left;
        cur_amt      = amt;
        cur_left     = left;
        repeat (cycles) tick();
        shift_amount = DW'($urandom);
        shift_left   = $urandom_range(0, 1);
        state        = DATA;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit last, input logic [1:0] st);
        int w;
        state    = st;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        for (w = 0; w < 100; w++) begin
            @(negedge clk);
            if (s_tready) break;
            tick();
        end
        if (w == 100) check("send_timeout", 0, 1);
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int w;
        s_tvalid = 1'b0;
        for (w = 0; w < 200; w++) begin
            @(negedge clk);
            if (sb.size() == 0 && !m_tvalid) break;
            tick();
        end
        if (w == 200) check("drain_timeout", 0, 1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; state = PREAM; shift_amount = '0; shift_left = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_m_tvalid", m_tvalid, 0);
        check("reset_m_tdata", m_tdata, 0);
        check("reset_m_tlast", m_tlast, 0);
        check("reset_sat_count", sat_count, 0);
        tick();

        // Left shift by 7, single sample, latency checked.
        lat_chk = 1'b1;
        pream(7, 1'b1, 2);
        send(16'h0001, 1'b0, DATA);
        drain();

        // Right shift by 2 with rounding, back-to-back.
        pream(2, 1'b0, 2);
        send(16'h0300, 1'b0, DATA);
        send(16'h0302, 1'b0, QUIET);
        send(16'h0301, 1'b0, FINAL);
        drain();

        // Saturation and clear on next layer.
        send(16'h0400, 1'b0, DATA);
        drain();
        @(negedge clk);
        check("sat_count_after_sat", sat_count, 1);
        tick();
        pream(20, 1'b0, 3);
        @(negedge clk);
        check("sat_count_cleared", sat_count, 0);
        tick();

        // Clamped shift of 15 and tlast alignment.
        for (int i = 0; i < 4; i++) send(16'hFFFF, (i == 3), DATA);
        drain();
        lat_chk = 1'b0;

        // Backpressure: three stalled cycles.
        pream(1, 1'b1, 2);
        m_tready = 1'b0;
        send(16'h0010, 1'b0, DATA);
        send(16'h0011, 1'b0, DATA);
        s_tdata = 16'h0012; s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_s_tready", s_tready, 0);
            check("bp_m_tdata", m_tdata, 8'h20);
            check("bp_m_tvalid", m_tvalid, 1);
            tick();
        end
        m_tready = 1'b1;
        send(16'h0012, 1'b1, QUIET);
        drain();

        // Shift update in PREAM while samples are still in flight.
        pream(3, 1'b0, 2);
        send(16'h0123, 1'b0, DATA);
        send(16'h0456, 1'b0, DATA);
        pream(2, 1'b1, 2);
        send(16'h0021, 1'b1, FINAL);
        drain();

        // Randomized layers with random backpressure and idle gaps.
        rand_ready = 1'b1;
        for (int layer = 0; layer < 8; layer++) begin
            int nsamp;
            bit lft;
            lft = $urandom_range(0, 1);
            pream($urandom_range(0, 20), lft, $urandom_range(2, 4));
            nsamp = $urandom_range(20, 40);
            for (int k = 0; k < nsamp; k++) begin
                logic [DW-1:0] d;
                d = lft ? DW'($urandom_range(0, 300)) : DW'($urandom);
                send(d, ($urandom_range(0, 7) == 0), 2'($urandom_range(1, 3)));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            end
        end
        rand_ready = 1'b0;
        tick();
        m_tready = 1'b1;
        drain();

        // Reset with two samples in flight.
        pream(0, 1'b0, 2);
        send(16'h01FF, 1'b0, DATA);
        drain();
        @(negedge clk);
        check("sat_before_rst", sat_count, 1);
        tick();
        send(16'h0005, 1'b0, DATA);
        send(16'h0006, 1'b1, DATA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_sat_count", sat_count, 0);
        tick();
        repeat (5) tick();

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
